// File: rtl/hazard_unit_sb.sv
// hazard_unit_sb: EX forwarding, load-use and taken-branch control, plus a scoreboard for long-latency writebacks.
module hazard_unit_sb #(
    parameter int REG_AW    = 5,
    parameter int NREGS     = 32,
    parameter int MAX_OUTST = 4,
    parameter int CNT_W     = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [REG_AW-1:0]              id_rs1,
    input  logic [REG_AW-1:0]              id_rs2,
    input  logic                           id_use_rs1,
    input  logic                           id_use_rs2,
    input  logic [REG_AW-1:0]              id_rd,
    input  logic                           id_wb,
    input  logic                           id_long,
    input  logic [REG_AW-1:0]              id_ex_rs1,
    input  logic [REG_AW-1:0]              id_ex_rs2,
    input  logic [REG_AW-1:0]              id_ex_rd,
    input  logic                           id_ex_wb,
    input  logic                           id_ex_memread,
    input  logic                           id_ex_long,
    input  logic [REG_AW-1:0]              ex_mem_rd,
    input  logic [REG_AW-1:0]              mem_wb_rd,
    input  logic                           ex_mem_wb,
    input  logic                           mem_wb_wb,
    input  logic                           long_done,
    input  logic [REG_AW-1:0]              long_rd,
    input  logic                           branch_taken,
    output logic [1:0]                     forwardingA,
    output logic [1:0]                     forwardingB,
    output logic                           stall_if,
    output logic                           stall_id,
    output logic                           flush_id,
    output logic                           flush_ex,
    output logic [NREGS-1:0]               sb_busy,
    output logic [$clog2(MAX_OUTST+1)-1:0] outst_cnt,
    output logic [CNT_W-1:0]               stall_cycles
);
    localparam int OW = $clog2(MAX_OUTST + 1);

    logic             ex_mem_ok, mem_wb_ok, lu, sbh, hazard, at_max, sb_set, sb_clr;
    logic [NREGS-1:0] set_mask, clr_mask;

    always_comb begin
        ex_mem_ok   = ex_mem_wb && ex_mem_rd != '0;
        mem_wb_ok   = mem_wb_wb && mem_wb_rd != '0;
        forwardingA = rst ? 2'b00 : (ex_mem_ok && ex_mem_rd == id_ex_rs1) ? 2'b10 :
                      (mem_wb_ok && mem_wb_rd == id_ex_rs1) ? 2'b01 : 2'b00;
        forwardingB = rst ? 2'b00 : (ex_mem_ok && ex_mem_rd == id_ex_rs2) ? 2'b10 :
                      (mem_wb_ok && mem_wb_rd == id_ex_rs2) ? 2'b01 : 2'b00;
        at_max      = outst_cnt == OW'(MAX_OUTST);
        lu          = id_ex_memread && id_ex_rd != '0 &&
                      ((id_use_rs1 && id_rs1 == id_ex_rd) || (id_use_rs2 && id_rs2 == id_ex_rd));
        sbh         = (id_use_rs1 && sb_busy[id_rs1]) || (id_use_rs2 && sb_busy[id_rs2]) ||
                      (id_wb && id_rd != '0 && sb_busy[id_rd]) || (id_long && at_max);
        hazard      = lu || sbh;
        flush_id    = !rst && branch_taken;
        flush_ex    = !rst && (branch_taken || hazard);
        stall_if    = !rst && !branch_taken && hazard;
        stall_id    = stall_if;
        // a flushed EX slot carries cleared controls, so no extra qualification is needed on issue
        sb_set      = id_ex_long && id_ex_wb && id_ex_rd != '0;
        sb_clr      = long_done && long_rd != '0 && sb_busy[long_rd];
        set_mask    = NREGS'(sb_set) << id_ex_rd;
        clr_mask    = NREGS'(sb_clr) << long_rd;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sb_busy      <= '0;
            outst_cnt    <= '0;
            stall_cycles <= '0;
        end else begin
            sb_busy <= (sb_busy & ~clr_mask) | set_mask;
            if (sb_set && !sb_clr)
                outst_cnt <= at_max ? outst_cnt : outst_cnt + 1'b1;
            else if (sb_clr && !sb_set)
                outst_cnt <= outst_cnt - 1'b1;
            if (stall_id && !(&stall_cycles))
                stall_cycles <= stall_cycles + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst)
            assert (!(sb_set && !sb_clr && at_max));
    end
endmodule

// File: tb/tb_hazard_unit_sb.sv
// tb_hazard_unit_sb: directed plus randomized checks against a behavioural scoreboard model.
module tb_hazard_unit_sb;
    localparam int MAXO = 4;

    logic       clk = 1'b0, rst;
    logic [4:0] id_rs1, id_rs2, id_rd, id_ex_rs1, id_ex_rs2, id_ex_rd, ex_mem_rd, mem_wb_rd, long_rd;
    logic       id_use_rs1, id_use_rs2, id_wb, id_long, id_ex_wb, id_ex_memread, id_ex_long;
    logic       ex_mem_wb, mem_wb_wb, long_done, branch_taken;
    logic [1:0] forwardingA, forwardingB;
    logic       stall_if, stall_id, flush_id, flush_ex;
    logic [31:0] sb_busy;
    logic [2:0]  outst_cnt;
    logic [15:0] stall_cycles;

    int errors = 0, checks = 0;
    bit busy[32];
    int cnt, stalls;

    hazard_unit_sb dut (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1),
        .id_use_rs2(id_use_rs2), .id_rd(id_rd), .id_wb(id_wb), .id_long(id_long),
        .id_ex_rs1(id_ex_rs1), .id_ex_rs2(id_ex_rs2), .id_ex_rd(id_ex_rd), .id_ex_wb(id_ex_wb),
        .id_ex_memread(id_ex_memread), .id_ex_long(id_ex_long), .ex_mem_rd(ex_mem_rd),
        .mem_wb_rd(mem_wb_rd), .ex_mem_wb(ex_mem_wb), .mem_wb_wb(mem_wb_wb),
        .long_done(long_done), .long_rd(long_rd), .branch_taken(branch_taken),
        .forwardingA(forwardingA), .forwardingB(forwardingB), .stall_if(stall_if),
        .stall_id(stall_id), .flush_id(flush_id), .flush_ex(flush_ex), .sb_busy(sb_busy),
        .outst_cnt(outst_cnt), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_in();
        {id_rs1, id_rs2, id_rd, id_ex_rs1, id_ex_rs2, id_ex_rd, ex_mem_rd, mem_wb_rd, long_rd} = '0;
        {id_use_rs1, id_use_rs2, id_wb, id_long, id_ex_wb, id_ex_memread, id_ex_long} = '0;
        {ex_mem_wb, mem_wb_wb, long_done, branch_taken} = '0;
    endtask

    function automatic int m_fwd(input logic [4:0] src);
        if (ex_mem_wb && ex_mem_rd != 0 && ex_mem_rd == src) return 2;
        if (mem_wb_wb && mem_wb_rd != 0 && mem_wb_rd == src) return 1;
        return 0;
    endfunction

    function automatic bit m_hazard();
        bit lu, sbh;
        lu  = id_ex_memread && id_ex_rd != 0 &&
              ((id_use_rs1 && id_rs1 == id_ex_rd) || (id_use_rs2 && id_rs2 == id_ex_rd));
        sbh = (id_use_rs1 && busy[id_rs1]) || (id_use_rs2 && busy[id_rs2]) ||
              (id_wb && id_rd != 0 && busy[id_rd]) || (id_long && cnt == MAXO);
        return lu || sbh;
    endfunction

    function automatic logic [31:0] m_busy();
        logic [31:0] v = '0;
        for (int r = 0; r < 32; r++) v[r] = busy[r];
        return v;
    endfunction

    function automatic bit m_stall();
        return !rst && !branch_taken && m_hazard();
    endfunction

    task automatic check_all();
        chk("fwdA", 32'(forwardingA), rst ? 0 : m_fwd(id_ex_rs1));
        chk("fwdB", 32'(forwardingB), rst ? 0 : m_fwd(id_ex_rs2));
        chk("stall_if", 32'(stall_if), 32'(m_stall()));
        chk("stall_id", 32'(stall_id), 32'(m_stall()));
        chk("flush_id", 32'(flush_id), 32'(!rst && branch_taken));
        chk("flush_ex", 32'(flush_ex), 32'(!rst && (branch_taken || m_hazard())));
        chk("sb_busy", sb_busy, m_busy());
        chk("outst_cnt", 32'(outst_cnt), cnt);
        chk("stall_cycles", 32'(stall_cycles), stalls);
    endtask

    task automatic model_update(input bit st);
        bit set, clr;
        if (rst) begin
            foreach (busy[r]) busy[r] = 0;
            cnt = 0;
            stalls = 0;
            return;
        end
        set = id_ex_long && id_ex_wb && id_ex_rd != 0;
        clr = long_done && long_rd != 0 && busy[long_rd];
        if (clr) busy[long_rd] = 0;
        if (set) busy[id_ex_rd] = 1;
        if (set && !clr && cnt < MAXO) cnt++;
        if (clr && !set) cnt--;
        if (st && stalls < 65535) stalls++;
    endtask

    task automatic tick();
        bit st;
        #1 check_all();
        st = m_stall();
        @(posedge clk);
        model_update(st);
        #1;
    endtask

    initial begin
        foreach (busy[r]) busy[r] = 0;
        cnt = 0; stalls = 0;
        clear_in();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;

        ex_mem_rd = 5; mem_wb_rd = 5; ex_mem_wb = 1; mem_wb_wb = 1; id_ex_rs1 = 5;
        #1 chk("fwdA_exmem", 32'(forwardingA), 2);
        chk("fwdB_r0", 32'(forwardingB), 0);
        ex_mem_wb = 0;
        #1 chk("fwdA_memwb", 32'(forwardingA), 1);
        tick();

        clear_in();
        id_ex_memread = 1; id_ex_rd = 7; id_rs2 = 7; id_use_rs2 = 1;
        #1 chk("lu_stall", 32'(stall_id), 1);
        chk("lu_bubble", 32'(flush_ex), 1);
        id_use_rs2 = 0;
        #1 chk("lu_unused", 32'(stall_id), 0);
        tick();

        clear_in();
        id_ex_long = 1; id_ex_wb = 1; id_ex_rd = 9;
        tick();
        clear_in();
        #1 chk("sb9_set", 32'(sb_busy[9]), 1);
        chk("outst_1", 32'(outst_cnt), 1);
        id_rs1 = 9; id_use_rs1 = 1;
        for (int i = 0; i < 5; i++) begin
            #1 chk("raw_hold", 32'(stall_id), 1);
            tick();
        end
        long_done = 1; long_rd = 9;
        #1 chk("raw_last", 32'(stall_id), 1);
        tick();
        long_done = 0;
        #1 chk("raw_release", 32'(stall_id), 0);
        chk("stall_cnt6", 32'(stall_cycles), 6);
        tick();

        clear_in();
        for (int r = 1; r <= 4; r++) begin
            id_ex_long = 1; id_ex_wb = 1; id_ex_rd = 5'(r);
            tick();
        end
        clear_in();
        #1 chk("outst_max", 32'(outst_cnt), 4);
        id_long = 1;
        #1 chk("limit_stall", 32'(stall_id), 1);
        tick();
        clear_in();
        long_done = 1; long_rd = 2; id_ex_long = 1; id_ex_wb = 1; id_ex_rd = 5;
        tick();
        clear_in();
        #1 chk("swap_cnt", 32'(outst_cnt), 4);
        chk("swap_clr2", 32'(sb_busy[2]), 0);
        chk("swap_set5", 32'(sb_busy[5]), 1);

        id_ex_memread = 1; id_ex_rd = 7; id_rs1 = 7; id_use_rs1 = 1; branch_taken = 1;
        #1 chk("br_flush_id", 32'(flush_id), 1);
        chk("br_flush_ex", 32'(flush_ex), 1);
        chk("br_no_stall", 32'(stall_if), 0);
        tick();

        clear_in();
        long_done = 1; long_rd = 0;
        tick();
        long_rd = 6;
        tick();
        #1 chk("ign_cnt", 32'(outst_cnt), 4);
        chk("ign_busy", sb_busy, 32'h3a);
        long_rd = 1;
        tick();

        clear_in();
        rst = 1; ex_mem_wb = 1; ex_mem_rd = 5; id_ex_rs1 = 5; id_rs1 = 3; id_use_rs1 = 1;
        #1 chk("rst_fwdA", 32'(forwardingA), 0);
        chk("rst_stall", 32'(stall_id), 0);
        chk("rst_flush", 32'(flush_ex), 0);
        tick();
        rst = 0;
        clear_in();
        #1 chk("rst_busy", sb_busy, 0);
        chk("rst_cnt", 32'(outst_cnt), 0);
        chk("rst_stalls", 32'(stall_cycles), 0);
        long_done = 1; long_rd = 3;
        tick();
        #1 chk("stale_done", 32'(outst_cnt), 0);

        for (int n = 0; n < 600; n++) begin
            rst           = $urandom_range(0, 99) == 0;
            id_rs1        = 5'($urandom_range(0, 7));
            id_rs2        = 5'($urandom_range(0, 7));
            id_rd         = 5'($urandom_range(0, 7));
            id_use_rs1    = 1'($urandom_range(0, 1));
            id_use_rs2    = 1'($urandom_range(0, 1));
            id_wb         = 1'($urandom_range(0, 1));
            id_long       = $urandom_range(0, 3) == 0;
            id_ex_rs1     = 5'($urandom_range(0, 7));
            id_ex_rs2     = 5'($urandom_range(0, 7));
            id_ex_rd      = 5'($urandom_range(0, 7));
            id_ex_wb      = $urandom_range(0, 3) != 0;
            id_ex_memread = $urandom_range(0, 3) == 0;
            id_ex_long    = $urandom_range(0, 2) == 0;
            ex_mem_rd     = 5'($urandom_range(0, 7));
            mem_wb_rd     = 5'($urandom_range(0, 7));
            ex_mem_wb     = 1'($urandom_range(0, 1));
            mem_wb_wb     = 1'($urandom_range(0, 1));
            long_done     = $urandom_range(0, 2) == 0;
            long_rd       = 5'($urandom_range(0, 7));
            branch_taken  = $urandom_range(0, 7) == 0;
            // never issue into a full scoreboard unless a completion frees a slot that cycle
            if (!rst && cnt == MAXO && id_ex_wb && id_ex_rd != 0 &&
                !(long_done && long_rd != 0 && busy[long_rd]))
                id_ex_long = 0;
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
